ps2_scan_code_receiver: RTL and testbench

- Receives PS/2 keyboard frames on the ps2_clk/ps2_data lines and delivers 8-bit scan codes to the display and cipher path.
- Produces the scan_code bus that the seven-segment display decoder consumes.
- Performs synchronization, frame deserialization, parity and stop-bit checking, and timeout recovery.
- Folds F0 break and E0 extended prefixes into flags, so downstream logic sees one event per key action.

---
 rtl/ps2_scan_code_receiver_pkg.sv | 22 ++
 rtl/ps2_scan_code_receiver_if.sv | 29 ++
 rtl/ps2_scan_code_receiver_sync_edge.sv | 35 +++
 rtl/ps2_scan_code_receiver.sv | 180 ++++++++++++++++++
 tb/tb_ps2_scan_code_receiver.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/ps2_scan_code_receiver_pkg.sv
// Shared constants and types for the PS/2 scan-code receiver.
// Prefix byte values, the receive FSM encoding and the odd-parity helper.
`timescale 1ns/1ps
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK       = 8'hF0;
    localparam logic [7:0] PS2_EXTEND      = 8'hE0;
    localparam int         FRAME_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    // True when data bits plus the parity bit contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return (^data) ^ par;
    endfunction

endpackage

// File: rtl/ps2_scan_code_receiver_if.sv
// Bundle of the PS/2 line inputs and the decoded key-event outputs.
// The receiver uses the slave modport; the keyboard side / consumer uses master.
`timescale 1ns/1ps
interface ps2_scan_code_receiver_if;
    import ps2_pkg::*;

    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       key_release;
    logic       extended;
    logic       frame_error;
    rx_state_t  rx_state;

    // No backpressure: scan_valid, key_release and frame_error are one-cycle
    // strobes the consumer must sample every cycle; scan_code and extended are
    // stable while a strobe is high and hold their value until the next event.
    modport master (
        output ps2_clk, ps2_data,
        input  scan_code, scan_valid, key_release, extended, frame_error, rx_state
    );

    modport slave (
        input  ps2_clk, ps2_data,
        output scan_code, scan_valid, key_release, extended, frame_error, rx_state
    );

endinterface

// File: rtl/ps2_scan_code_receiver_sync_edge.sv
// Synchronizes the raw PS/2 clock and data lines into the system clock domain
// and flags the cycle on which the synchronized PS/2 clock falls.
`timescale 1ns/1ps
module ps2_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic data_sync,
    output logic fall_pulse
);

    logic [SYNC_STAGES-1:0] clk_pipe;
    logic [SYNC_STAGES-1:0] data_pipe;
    logic                   clk_prev;

    // Lines idle high, so reset to 1 to avoid a false edge after reset.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            clk_pipe  <= '1;
            data_pipe <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_pipe  <= {clk_pipe[SYNC_STAGES-2:0], ps2_clk};
            data_pipe <= {data_pipe[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_pipe[SYNC_STAGES-1];
        end
    end

    assign data_sync  = data_pipe[SYNC_STAGES-1];
    assign fall_pulse = clk_prev & ~clk_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/ps2_scan_code_receiver.sv
// PS/2 keyboard frame receiver: deserializes frames, checks parity/stop/timeout
// and folds F0/E0 prefixes into key_release/extended on a single event pulse.
`timescale 1ns/1ps
module ps2_scan_code_receiver
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                      clock,
    input  logic                      reset_n,
    ps2_scan_code_receiver_if.slave   bus
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]      LAST_BIT = 3'(FRAME_DATA_BITS - 1);

    logic [1:0] rst_pipe;
    logic       rst_n;

    // Reset asserts asynchronously and releases on a clock edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) rst_pipe <= 2'b00;
        else          rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign rst_n = rst_pipe[1];

    logic data_sync;
    logic fall_pulse;

    ps2_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clock      (clock),
        .rst_n      (rst_n),
        .ps2_clk    (bus.ps2_clk),
        .ps2_data   (bus.ps2_data),
        .data_sync  (data_sync),
        .fall_pulse (fall_pulse)
    );

    rx_state_t        state, next_state;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             parity_ok;
    logic [CNT_W-1:0] timeout_cnt;

    logic start_en, shift_en, parity_en, stop_ok, stop_bad, timeout_hit;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state  = state;
        start_en    = 1'b0;
        shift_en    = 1'b0;
        parity_en   = 1'b0;
        stop_ok     = 1'b0;
        stop_bad    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (fall_pulse && !data_sync) begin
                    start_en   = 1'b1;
                    next_state = DATA;
                end
            end
            DATA: begin
                if (fall_pulse) begin
                    shift_en = 1'b1;
                    if (bit_cnt == LAST_BIT) next_state = PARITY;
                end
            end
            PARITY: begin
                if (fall_pulse) begin
                    parity_en  = 1'b1;
                    next_state = STOP;
                end
            end
            STOP: begin
                if (fall_pulse) begin
                    next_state = IDLE;
                    if (data_sync && parity_ok) stop_ok  = 1'b1;
                    else                        stop_bad = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
        // A stalled partial frame is abandoned; a falling edge always wins.
        if (state != IDLE && !fall_pulse && timeout_cnt == CNT_LAST) begin
            timeout_hit = 1'b1;
            next_state  = IDLE;
            shift_en    = 1'b0;
            parity_en   = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt     <= 3'd0;
            shift_reg   <= 8'h00;
            parity_ok   <= 1'b0;
            timeout_cnt <= '0;
        end else begin
            if (start_en)      bit_cnt <= 3'd0;
            else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
            if (shift_en)  shift_reg <= {data_sync, shift_reg[7:1]};
            if (parity_en) parity_ok <= odd_parity_ok(shift_reg, data_sync);
            if (fall_pulse || state == IDLE) timeout_cnt <= '0;
            else if (timeout_cnt != CNT_LAST) timeout_cnt <= timeout_cnt + CNT_W'(1);
        end
    end

    // Frame result stage: gives the one-cycle gap between the stop edge and
    // the registered outputs.
    logic       rx_done, rx_err, rx_timeout;
    logic [7:0] rx_byte;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rx_done    <= 1'b0;
            rx_err     <= 1'b0;
            rx_timeout <= 1'b0;
            rx_byte    <= 8'h00;
        end else begin
            rx_done    <= stop_ok;
            rx_err     <= stop_bad | timeout_hit;
            rx_timeout <= timeout_hit;
            if (stop_ok) rx_byte <= shift_reg;
        end
    end

    logic [7:0] scan_code;
    logic       scan_valid, key_release, extended, frame_error;
    logic       break_pending, ext_pending;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            scan_code     <= 8'h00;
            scan_valid    <= 1'b0;
            key_release   <= 1'b0;
            extended      <= 1'b0;
            frame_error   <= 1'b0;
            break_pending <= 1'b0;
            ext_pending   <= 1'b0;
        end else begin
            scan_valid  <= 1'b0;
            key_release <= 1'b0;
            frame_error <= rx_err;
            if (rx_timeout) begin
                break_pending <= 1'b0;
                ext_pending   <= 1'b0;
            end else if (rx_done) begin
                if (rx_byte == PS2_BREAK) begin
                    break_pending <= 1'b1;
                end else if (rx_byte == PS2_EXTEND) begin
                    ext_pending <= 1'b1;
                end else begin
                    scan_code     <= rx_byte;
                    extended      <= ext_pending;
                    key_release   <= break_pending;
                    scan_valid    <= ~break_pending;
                    break_pending <= 1'b0;
                    ext_pending   <= 1'b0;
                end
            end
        end
    end

    assign bus.scan_code   = scan_code;
    assign bus.scan_valid  = scan_valid;
    assign bus.key_release = key_release;
    assign bus.extended    = extended;
    assign bus.frame_error = frame_error;
    assign bus.rx_state    = state;

endmodule

// File: tb/tb_ps2_scan_code_receiver.sv
// Bench for ps2_scan_code_receiver: a table of frames with expected events,
// plus hand-written latency, spurious-start, timeout and mid-frame reset cases.
`timescale 1ns/1ps
module tb_ps2_scan_code_receiver;
  import ps2_pkg::*;

  localparam int TIMEOUT = 200;
  localparam int SYNC    = 2;
  localparam int HALF    = 20;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  ps2_scan_code_receiver_if bus ();

  ps2_scan_code_receiver #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .SYNC_STAGES    (SYNC)
  ) u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_fall_cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // event = {scan_valid, key_release, frame_error, extended, scan_code}
  logic [11:0] exp_q[$];
  logic [11:0] obs_q[$];
  int          obs_cyc_q[$];

  always @(negedge clock) begin
    if (bus.scan_valid || bus.key_release || bus.frame_error) begin
      obs_q.push_back({bus.scan_valid, bus.key_release, bus.frame_error,
                       (bus.scan_valid | bus.key_release) & bus.extended, bus.scan_code});
      obs_cyc_q.push_back(cyc);
    end
  end

  function automatic logic [11:0] ev_valid(input logic [7:0] c, input logic e);
    return {3'b100, e, c};
  endfunction
  function automatic logic [11:0] ev_rel(input logic [7:0] c, input logic e);
    return {3'b010, e, c};
  endfunction
  function automatic logic [11:0] ev_err(input logic [7:0] c);
    return {4'b0010, c};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clock);
    bus.ps2_data = b;
    idle(HALF / 2);
    bus.ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    idle(HALF);
    bus.ps2_clk = 1'b1;
    idle(HALF / 2);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic flip_par,
                            input logic stop_bit, input int nbits);
    logic [10:0] f;
    f = {stop_bit, (~^b) ^ flip_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    bus.ps2_data = 1'b1;
    idle(8);
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic check_queue(input string name);
    bit bad;
    n_checks++;
    bad = (obs_q.size() != exp_q.size());
    if (!bad) foreach (exp_q[i]) if (obs_q[i] !== exp_q[i]) bad = 1'b1;
    if (bad) begin
      n_fail++;
      $display("FAIL %s: got %0d events first=%h, want %0d events first=%h", name,
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 12'h000,
               exp_q.size(), (exp_q.size() > 0) ? exp_q[0] : 12'h000);
    end
    exp_q.delete();
    obs_q.delete();
    obs_cyc_q.delete();
  endtask

  task automatic check_outputs_zero(input string name);
    check_val({name, "_code"}, 32'(bus.scan_code), 32'h00);
    check_val({name, "_flags"}, {28'd0, bus.scan_valid, bus.key_release, bus.extended, bus.frame_error}, 32'd0);
    check_val({name, "_state"}, 32'(bus.rx_state), 32'(IDLE));
  endtask

  // kind: 0 none, 1 make, 2 release, 3 error
  typedef struct {
    logic [7:0] data;
    logic       flip_par;
    logic       stop_bit;
    int         kind;
    logic       ext;
    logic [7:0] exp_code;
  } vec_t;

  vec_t vecs[16];

  initial begin
    int lat;
    logic [11:0] ev;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;

    vecs[0]  = '{8'h1C, 1'b0, 1'b1, 1, 1'b0, 8'h1C};
    vecs[1]  = '{8'hF0, 1'b0, 1'b1, 0, 1'b0, 8'h1C};
    vecs[2]  = '{8'h1C, 1'b0, 1'b1, 2, 1'b0, 8'h1C};
    vecs[3]  = '{8'h32, 1'b0, 1'b1, 1, 1'b0, 8'h32};
    vecs[4]  = '{8'hE0, 1'b0, 1'b1, 0, 1'b0, 8'h32};
    vecs[5]  = '{8'hF0, 1'b0, 1'b1, 0, 1'b0, 8'h32};
    vecs[6]  = '{8'h75, 1'b0, 1'b1, 2, 1'b1, 8'h75};
    vecs[7]  = '{8'h24, 1'b0, 1'b1, 1, 1'b0, 8'h24};
    vecs[8]  = '{8'h32, 1'b1, 1'b1, 3, 1'b0, 8'h24};
    vecs[9]  = '{8'h32, 1'b0, 1'b0, 3, 1'b0, 8'h24};
    vecs[10] = '{8'hF0, 1'b0, 1'b1, 0, 1'b0, 8'h24};
    vecs[11] = '{8'h5A, 1'b1, 1'b1, 3, 1'b0, 8'h24};
    vecs[12] = '{8'h1C, 1'b0, 1'b1, 2, 1'b0, 8'h1C};
    vecs[13] = '{8'hE0, 1'b0, 1'b1, 0, 1'b0, 8'h1C};
    vecs[14] = '{8'h6B, 1'b0, 1'b0, 3, 1'b0, 8'h1C};
    vecs[15] = '{8'h6B, 1'b0, 1'b1, 1, 1'b1, 8'h6B};

    // Reset state
    reset_n = 1'b0;
    idle(5);
    check_outputs_zero("reset");
    reset_n = 1'b1;
    idle(5);

    // Falling edge with data high is not a start bit
    ps2_bit(1'b1);
    idle(5);
    check_val("spurious_state", 32'(bus.rx_state), 32'(IDLE));
    check_queue("spurious_events");

    // First frame with latency measured from the raw stop-bit fall
    send_frame(8'h43, 1'b0, 1'b1, 11);
    lat = (obs_cyc_q.size() > 0) ? obs_cyc_q[0] - last_fall_cyc : -1;
    check_val("latency", 32'(lat), 32'(SYNC + 2));
    exp_q.push_back(ev_valid(8'h43, 1'b0));
    check_queue("first_frame");

    for (int i = 0; i < 16; i++) begin
      send_frame(vecs[i].data, vecs[i].flip_par, vecs[i].stop_bit, 11);
      case (vecs[i].kind)
        1: ev = ev_valid(vecs[i].exp_code, vecs[i].ext);
        2: ev = ev_rel(vecs[i].exp_code, vecs[i].ext);
        default: ev = ev_err(vecs[i].exp_code);
      endcase
      if (vecs[i].kind != 0) exp_q.push_back(ev);
      check_queue($sformatf("vec%0d_events", i));
      check_val($sformatf("vec%0d_code", i), 32'(bus.scan_code), 32'(vecs[i].exp_code));
    end

    // Timeout: F0 prefix, then a frame stalled after 4 data bits
    send_frame(8'hF0, 1'b0, 1'b1, 11);
    check_queue("to_prefix");
    send_frame(8'h24, 1'b0, 1'b1, 5);
    idle(140);
    check_val("to_not_yet_state", 32'(bus.rx_state), 32'(DATA));
    check_queue("to_not_yet_events");
    idle(80);
    exp_q.push_back(ev_err(8'h6B));
    check_queue("to_error");
    check_val("to_state", 32'(bus.rx_state), 32'(IDLE));
    send_frame(8'h24, 1'b0, 1'b1, 11);
    exp_q.push_back(ev_valid(8'h24, 1'b0));
    check_queue("after_timeout");

    // Reset in the middle of a frame
    send_frame(8'h43, 1'b0, 1'b1, 6);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    idle(3);
    reset_n = 1'b1;
    idle(5);
    check_queue("midreset_events");
    send_frame(8'h43, 1'b0, 1'b1, 11);
    exp_q.push_back(ev_valid(8'h43, 1'b0));
    check_queue("after_reset");
    check_val("after_reset_code", 32'(bus.scan_code), 32'h43);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got timeout, want end of test");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
